sram_phy_model: RTL and testbench
=================================

Name: sram_phy_model

Overview:
- Synthesizable responder for the external asynchronous SRAM phy interface. It is the device end of the bus that the SRAM arbiter drives.
- It takes the arbiter's address, chip/output/write enables and write data. It returns read data with a configurable latency.
- Used in simulation benches and in FPGA builds without the physical SRAM.
- Also counts accesses and flags out-of-range addresses for debug.

Parameters:
- aw, 19, address width of the phy bus.
- dw, 8, data width.
- depth_log2, 10, log2 of implemented words. Only addr[depth_log2-1:0] is used; upper bits alias.
- latency, 1, read latency in clock edges. Legal range 1..4.
- wr_data_delay, 1, edges between write command sample and write data sample. Legal values 0 or 1. 1 matches the arbiter's registered write data.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sram_addr  in  aw  word address
- sram_ce_n  in  1  chip enable, active low
- sram_oe_n  in  1  output enable, active low
- sram_we_n  in  1  write enable, active low
- sram_dat_wr  in  dw  write data from the controller
- sram_dat_rd  out  dw  read data to the controller
- rd_valid  out  1  sram_dat_rd holds a completed read (bench aid)
- wr_count  out  16  committed writes, saturating
- rd_count  out  16  completed reads, saturating
- oob_flag  out  1  sticky: an access had nonzero addr bits above depth_log2

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- All control inputs are sampled on posedge clk.
- Reset values: sram_dat_rd=0, rd_valid=0, wr_count=0, rd_count=0, oob_flag=0.
- Reset clears the pending-write register and the read pipeline. Memory contents are NOT reset.
- Write command: at edge N, ce_n=0 and we_n=0.
  - wr_data_delay=0: mem[addr] <= sram_dat_wr at edge N.
  - wr_data_delay=1: addr is captured into a pending register at edge N. At edge N+1, mem[pending_addr] <= sram_dat_wr. This commit happens regardless of ce_n/we_n at N+1.
- Back-to-back writes (delay 1): the commit of write k and the capture of write k+1 occur on the same edge. No bubble and no data loss.
- Read command: at edge N, ce_n=0, we_n=1, oe_n=0.
  - Stage 1 captures mem[addr] at edge N.
  - Write-first forwarding: if a write to the same aliased address commits at edge N, stage 1 takes the new data.
- Reads with ce_n=0, we_n=1, oe_n=1 are ignored. The output is not driven and rd_count does not change.
- Read pipeline:
  - Stage 1 plus latency-1 further register stages, each carrying a valid bit.
  - The last stage drives sram_dat_rd and rd_valid.
  - The result is visible in the cycle after edge N+latency-1. With latency=1 this aligns with the arbiter's registered read-valid.
- When the last stage is not valid, sram_dat_rd=0 and rd_valid=0.
- ce_n=1 means no new command at that edge. In-flight reads and any pending write still complete.
- ce_n=0, we_n=0 with oe_n=0: the write wins and no read is issued. The arbiter holds oe_n low permanently, so this is the normal case.
- Counters:
  - wr_count increments on each mem commit.
  - rd_count increments when a valid read leaves the last stage.
  - Both saturate at 0xFFFF.
- oob_flag is set at any command edge where addr[aw-1:depth_log2] != 0. It stays set until reset.
- Out-of-range accesses still alias and execute.
- Reset asserted mid-operation: the pending write is dropped (memory unchanged) and in-flight reads are discarded immediately.
- Out-of-range latency or wr_data_delay: elaboration error.

Decomposition:
- Shared package sram_pkg holds:
  - default aw/dw;
  - LATENCY_MIN=1 and LATENCY_MAX=4;
  - counter width 16;
  - the command encoding (IDLE, READ, WRITE) derived from ce_n/we_n/oe_n.
  The arbiter reuses it.
- One sub-module, sram_rd_pipe: a parameterized valid+data shift register of depth latency with async active-low reset.
- Memory array, pending-write register, forwarding and counters stay in the top.

Test Plan:
- Write then read, delay 1, latency 1:
  - Stimulus: write 0xA5 to addr 0x003 at edge 1 (data presented at edge 2); read 0x003 at edge 3.
  - Response: rd_valid=1 and sram_dat_rd=0xA5 in the cycle after edge 3; wr_count=1, rd_count=1.
- Back-to-back writes:
  - Stimulus: 4 writes to addrs 0..3 at consecutive edges (data 0x10..0x13, each lagging one cycle), then 4 reads.
  - Response: read data returns 0x10..0x13 in order, one per cycle.
- Read-after-write same edge:
  - Stimulus: write 0x3C to addr 7 at edge N; read addr 7 at edge N+1 (commit edge).
  - Response: read returns 0x3C (forwarding), not the old value.
- Latency sweep:
  - Stimulus: latency=3; read at edge N.
  - Response: rd_valid=0 for cycles N+1..N+2 and rd_valid=1 in the cycle after edge N+2; data is correct.
  - Also: oe_n=1 during a read produces no rd_valid.
- Aliasing and flag:
  - Stimulus: depth_log2=10; write 0x77 to addr 0x00405.
  - Response: oob_flag=1 and stays set; a read of addr 0x005 returns 0x77.
- Reset mid-operation:
  - Stimulus: latency=2; read in flight and a write pending when rst_n is pulled low.
  - Response: rd_valid=0, sram_dat_rd=0, counters=0 immediately; the pending write's address still holds its old data after reset releases.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared definitions for the external SRAM phy bus, used by the arbiter and the
// device-side responder model.
package sram_pkg;

    localparam int SRAM_AW     = 19;
    localparam int SRAM_DW     = 8;
    localparam int LATENCY_MIN = 1;
    localparam int LATENCY_MAX = 4;
    localparam int CNT_W       = 16;

    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_READ  = 2'd1,
        CMD_WRITE = 2'd2
    } sram_cmd_e;

    // Write has priority over read because the arbiter keeps oe_n low at all times.
    function automatic sram_cmd_e decode_cmd(input logic ce_n, input logic we_n, input logic oe_n);
        sram_cmd_e cmd;
        cmd = CMD_IDLE;
        if (!ce_n) begin
            if (!we_n) begin
                cmd = CMD_WRITE;
            end else if (!oe_n) begin
                cmd = CMD_READ;
            end
        end
        return cmd;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Valid+data shift register forming the read-latency pipeline of the SRAM model.
// The last stage drives the outputs; data is forced to zero when that stage is empty.
module sram_rd_pipe #(
    parameter int dw    = 8,
    parameter int depth = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [dw-1:0] in_data,
    output logic          out_valid,
    output logic [dw-1:0] out_data,
    output logic          last_load
);

    logic [depth-1:0] vld;
    logic [dw-1:0]    dat [depth];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < depth; i++) begin
                dat[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            dat[0] <= in_data;
            for (int i = 1; i < depth; i++) begin
                vld[i] <= vld[i-1];
                dat[i] <= dat[i-1];
            end
        end
    end

    // Asserted on the edge that moves a valid read into the last stage.
    generate
        if (depth == 1) begin : g_last_single
            assign last_load = in_valid;
        end else begin : g_last_multi
            assign last_load = vld[depth-2];
        end
    endgenerate

    assign out_valid = vld[depth-1];
    assign out_data  = vld[depth-1] ? dat[depth-1] : '0;

endmodule

// File: rtl/sram_phy_model.sv
// Device-side responder for the asynchronous SRAM phy bus: memory array, delayed
// write-data commit, write-first read forwarding, access counters and out-of-range flag.
module sram_phy_model
    import sram_pkg::*;
#(
    parameter int aw            = SRAM_AW,
    parameter int dw            = SRAM_DW,
    parameter int depth_log2    = 10,
    parameter int latency       = 1,
    parameter int wr_data_delay = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [aw-1:0]    sram_addr,
    input  logic             sram_ce_n,
    input  logic             sram_oe_n,
    input  logic             sram_we_n,
    input  logic [dw-1:0]    sram_dat_wr,
    output logic [dw-1:0]    sram_dat_rd,
    output logic             rd_valid,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] rd_count,
    output logic             oob_flag
);

    localparam int DEPTH = 1 << depth_log2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    generate
        if (latency < LATENCY_MIN || latency > LATENCY_MAX) begin : g_bad_latency
            $error("sram_phy_model: latency must be within 1..4");
        end
        if (wr_data_delay != 0 && wr_data_delay != 1) begin : g_bad_wr_delay
            $error("sram_phy_model: wr_data_delay must be 0 or 1");
        end
        if (depth_log2 >= aw) begin : g_bad_depth
            $error("sram_phy_model: depth_log2 must be smaller than aw");
        end
    endgenerate

    sram_cmd_e             cmd;
    logic [depth_log2-1:0] addr_idx;
    logic                  addr_oob;
    logic                  commit_en;
    logic [depth_log2-1:0] commit_addr;
    logic [dw-1:0]         rd_word;
    logic                  rd_done;

    assign cmd      = decode_cmd(sram_ce_n, sram_we_n, sram_oe_n);
    assign addr_idx = sram_addr[depth_log2-1:0];
    assign addr_oob = |sram_addr[aw-1:depth_log2];

    // With delayed write data the address is held one edge and committed unconditionally.
    generate
        if (wr_data_delay == 0) begin : g_wr_direct
            assign commit_en   = (cmd == CMD_WRITE);
            assign commit_addr = addr_idx;
        end else begin : g_wr_pending
            logic                  pend_valid;
            logic [depth_log2-1:0] pend_addr;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pend_valid <= 1'b0;
                    pend_addr  <= '0;
                end else begin
                    pend_valid <= (cmd == CMD_WRITE);
                    pend_addr  <= addr_idx;
                end
            end

            assign commit_en   = pend_valid;
            assign commit_addr = pend_addr;
        end
    endgenerate

    logic [dw-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (commit_en) begin
            mem[commit_addr] <= sram_dat_wr;
        end
    end

    // A read landing on the commit edge of the same word sees the new data.
    assign rd_word = (commit_en && (commit_addr == addr_idx)) ? sram_dat_wr : mem[addr_idx];

    sram_rd_pipe #(
        .dw    (dw),
        .depth (latency)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (cmd == CMD_READ),
        .in_data   (rd_word),
        .out_valid (rd_valid),
        .out_data  (sram_dat_rd),
        .last_load (rd_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count <= '0;
            rd_count <= '0;
            oob_flag <= 1'b0;
        end else begin
            if (commit_en && (wr_count != CNT_MAX)) begin
                wr_count <= wr_count + 1'b1;
            end
            if (rd_done && (rd_count != CNT_MAX)) begin
                rd_count <= rd_count + 1'b1;
            end
            if ((cmd != CMD_IDLE) && addr_oob) begin
                oob_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sram_phy_model.sv
// Scoreboard bench for sram_phy_model: three instances (latency 1, 2, 3) share one bus;
// a reference memory predicts each read and per-instance queues hold results until due.
module tb_sram_phy_model;
    import sram_pkg::*;

    typedef enum {OP_IDLE, OP_READ, OP_WRITE, OP_READ_NOOE} op_e;

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [18:0] sram_addr;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [7:0]  sram_dat_wr;

    logic [7:0]  rd_dat  [3];
    logic        rd_vld  [3];
    logic [15:0] wr_cnt  [3];
    logic [15:0] rd_cnt  [3];
    logic        oob     [3];

    for (genvar k = 0; k < 3; k++) begin : g_dut
        sram_phy_model #(
            .aw            (19),
            .dw            (8),
            .depth_log2    (10),
            .latency       (k + 1),
            .wr_data_delay (1)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .sram_addr   (sram_addr),
            .sram_ce_n   (sram_ce_n),
            .sram_oe_n   (sram_oe_n),
            .sram_we_n   (sram_we_n),
            .sram_dat_wr (sram_dat_wr),
            .sram_dat_rd (rd_dat[k]),
            .rd_valid    (rd_vld[k]),
            .wr_count    (wr_cnt[k]),
            .rd_count    (rd_cnt[k]),
            .oob_flag    (oob[k])
        );
    end

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    int vectors     = 0;
    int miscompares = 0;

    exp_t       q0 [$];
    exp_t       q1 [$];
    exp_t       q2 [$];
    logic [7:0] model_mem [1024];
    bit         tb_pend;
    logic [9:0] tb_pend_addr;
    logic [7:0] tb_pend_data;
    int         wr_exp;
    int         rd_exp [3];
    bit         oob_exp;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h at edge %0d", tag, actual, expected, edge_cnt);
        end
    endtask

    // Drives one bus command for the next edge and advances the reference model to that edge.
    task automatic applyStimulus(input op_e op, input logic [18:0] addr, input logic [7:0] data);
        exp_t e;
        @(negedge clk);
        sram_addr   = addr;
        sram_ce_n   = (op == OP_IDLE);
        sram_we_n   = (op != OP_WRITE);
        sram_oe_n   = (op == OP_READ_NOOE);
        sram_dat_wr = tb_pend ? tb_pend_data : 8'($urandom);
        if (tb_pend) begin
            model_mem[tb_pend_addr] = tb_pend_data;
            wr_exp++;
        end
        if (op == OP_READ) begin
            e.data = model_mem[addr[9:0]];
            e.due  = edge_cnt + 1;
            q0.push_back(e);
            e.due  = edge_cnt + 2;
            q1.push_back(e);
            e.due  = edge_cnt + 3;
            q2.push_back(e);
        end
        if ((op == OP_READ || op == OP_WRITE) && (addr[18:10] != 9'd0)) begin
            oob_exp = 1'b1;
        end
        tb_pend      = (op == OP_WRITE);
        tb_pend_addr = addr[9:0];
        tb_pend_data = data;
    endtask

    task automatic check_inst(input int k);
        exp_t e;
        bit   hit;
        hit = 1'b0;
        case (k)
            0: if (q0.size() > 0 && q0[0].due == edge_cnt) begin e = q0.pop_front(); hit = 1'b1; end
            1: if (q1.size() > 0 && q1[0].due == edge_cnt) begin e = q1.pop_front(); hit = 1'b1; end
            default: if (q2.size() > 0 && q2[0].due == edge_cnt) begin e = q2.pop_front(); hit = 1'b1; end
        endcase
        if (hit) begin
            rd_exp[k]++;
            checkOutput($sformatf("rd_valid_lat%0d", k + 1), rd_vld[k], 1);
            checkOutput($sformatf("rd_data_lat%0d", k + 1), rd_dat[k], e.data);
        end else begin
            checkOutput($sformatf("rd_valid_idle_lat%0d", k + 1), rd_vld[k], 0);
            checkOutput($sformatf("rd_data_idle_lat%0d", k + 1), rd_dat[k], 0);
        end
        checkOutput($sformatf("rd_count_lat%0d", k + 1), rd_cnt[k], rd_exp[k]);
        checkOutput($sformatf("wr_count_lat%0d", k + 1), wr_cnt[k], wr_exp);
        checkOutput($sformatf("oob_flag_lat%0d", k + 1), oob[k], oob_exp);
    endtask

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 3; k++) begin
            check_inst(k);
        end
    end

    // Pulls reset between edges while a read is in flight and a write is pending.
    task automatic reset_mid_operation();
        @(negedge clk);
        rst_n       = 1'b0;
        sram_ce_n   = 1'b1;
        sram_we_n   = 1'b1;
        sram_dat_wr = 8'($urandom);
        tb_pend     = 1'b0;
        wr_exp      = 0;
        oob_exp     = 1'b0;
        q0.delete();
        q1.delete();
        q2.delete();
        for (int k = 0; k < 3; k++) rd_exp[k] = 0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("rst_rd_valid_lat%0d", k + 1), rd_vld[k], 0);
            checkOutput($sformatf("rst_rd_data_lat%0d", k + 1), rd_dat[k], 0);
            checkOutput($sformatf("rst_wr_count_lat%0d", k + 1), wr_cnt[k], 0);
            checkOutput($sformatf("rst_rd_count_lat%0d", k + 1), rd_cnt[k], 0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        sram_addr   = '0;
        sram_ce_n   = 1'b1;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b0;
        sram_dat_wr = '0;
        tb_pend     = 1'b0;
        wr_exp      = 0;
        oob_exp     = 1'b0;
        for (int k = 0; k < 3; k++) rd_exp[k] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(OP_WRITE, 19'h00003, 8'hA5);
        applyStimulus(OP_IDLE,  19'h00000, 8'h00);
        applyStimulus(OP_READ,  19'h00003, 8'h00);
        repeat (4) applyStimulus(OP_IDLE, 19'h00000, 8'h00);

        for (int i = 0; i < 4; i++) applyStimulus(OP_WRITE, 19'(i), 8'(8'h10 + i));
        for (int i = 0; i < 4; i++) applyStimulus(OP_READ, 19'(i), 8'h00);
        repeat (4) applyStimulus(OP_IDLE, 19'h00000, 8'h00);

        applyStimulus(OP_WRITE, 19'h00007, 8'h99);
        applyStimulus(OP_IDLE,  19'h00000, 8'h00);
        applyStimulus(OP_IDLE,  19'h00000, 8'h00);
        applyStimulus(OP_WRITE, 19'h00007, 8'h3C);
        applyStimulus(OP_READ,  19'h00007, 8'h00);
        repeat (4) applyStimulus(OP_IDLE, 19'h00000, 8'h00);

        applyStimulus(OP_READ_NOOE, 19'h00003, 8'h00);
        applyStimulus(OP_READ,      19'h00002, 8'h00);
        repeat (4) applyStimulus(OP_IDLE, 19'h00000, 8'h00);

        applyStimulus(OP_WRITE, 19'h00405, 8'h77);
        applyStimulus(OP_IDLE,  19'h00000, 8'h00);
        applyStimulus(OP_READ,  19'h00005, 8'h00);
        repeat (4) applyStimulus(OP_IDLE, 19'h00000, 8'h00);

        applyStimulus(OP_WRITE, 19'h00020, 8'h55);
        applyStimulus(OP_IDLE,  19'h00000, 8'h00);
        repeat (3) applyStimulus(OP_IDLE, 19'h00000, 8'h00);
        applyStimulus(OP_READ,  19'h00003, 8'h00);
        applyStimulus(OP_WRITE, 19'h00020, 8'hEE);
        reset_mid_operation();
        applyStimulus(OP_READ,  19'h00020, 8'h00);
        applyStimulus(OP_READ,  19'h00007, 8'h00);
        repeat (6) applyStimulus(OP_IDLE, 19'h00000, 8'h00);

        checkOutput("drain_queues", q0.size() + q1.size() + q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
